// File: rtl/rotate_buf_pkg.sv
// Shared types and sizing constants for the rotate frame-buffer controller and its output FIFO.
package rotate_buf_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        DRAINING
    } bank_st_t;

    typedef enum logic {
        W_WAIT,
        W_FILL
    } wr_st_t;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rd_st_t;

    localparam int PIX_PER_TILE   = 2048;
    localparam int WORDS_PER_BANK = 128;

endpackage

// File: rtl/rotate_buf_ofifo.sv
// 2-entry output FIFO plus RAM read in-flight tracking; push 1 cycle after issue, head is the output.
// Issue credit counts a same-cycle pop so a 1 word/cycle stream never bubbles; holds head while m_ready is low.
module rotate_buf_ofifo #(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          issue_last,
    output logic          can_issue,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic [1:0]    last_q, last_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;
    logic [2:0]    pend;

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = mem_q[rd_ptr_q];
    assign m_last  = last_q[rd_ptr_q];
    assign pop     = m_valid && m_ready;

    always_comb begin
        infl_d      = issue;
        infl_last_d = issue_last;
        mem_d       = mem_q;
        last_d      = last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        // Pending words after this cycle's pop; a pop implies cnt_q >= 1.
        pend        = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
        can_issue   = (pend < 3'd2);
        if (infl_q) begin
            mem_d[wr_ptr_q]  = rd_data;
            last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = 2'(pend);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            last_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            mem_q       <= mem_d;
            last_q      <= last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/rotate_buf_ctrl.sv
// Ping-pong rotate buffer sequencer: raster pixels in, 90-degree rotated 256-bit rows out (ROTATE_BUF_CTRL_CCW_EN selects CCW).
// Last pixel to first m_valid is 4 cycles; s_ready drops only while the next write bank is still draining.
module rotate_buf_ctrl
    import rotate_buf_pkg::*;
#(
    parameter int PIX_W     = 16,
    parameter int TILE_ROWS = 16,
    parameter int TILE_COLS = 128,
    parameter int WR_AW     = 12,
    parameter int RD_AW     = 8,
    parameter int RD_DW     = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_first,
    output logic             ram_wr_en,
    output logic [WR_AW-1:0] ram_wr_addr,
    output logic [PIX_W-1:0] ram_wr_data,
    output logic [RD_AW-1:0] ram_rd_addr,
    input  logic [RD_DW-1:0] ram_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [RD_DW-1:0] m_data,
    output logic             m_last,
    output logic             tile_err
);

    localparam int CW    = $clog2(TILE_COLS);
    localparam int RW    = $clog2(TILE_ROWS);
    localparam int CNT_W = CW + RW;
    localparam int WD    = $clog2(WORDS_PER_BANK);

    wr_st_t           wr_st_q, wr_st_d;
    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    bank_st_t         bank_q [2];
    bank_st_t         bank_d [2];
    logic             tile_err_q, tile_err_d;
    logic             wr_en_q, wr_en_d;
    logic [WR_AW-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0] wr_data_q, wr_data_d;
    rd_st_t           rd_st_q, rd_st_d;
    logic             rd_bank_q, rd_bank_d;
    logic [WD-1:0]    rd_word_q, rd_word_d;
    logic             rd_all_q, rd_all_d;

    logic             hs;
    logic [CNT_W-1:0] pos;
    logic [RW-1:0]    r;
    logic [CW-1:0]    c;
    logic             issue, issue_last, can_issue;

    assign s_ready     = (wr_st_q == W_FILL);
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign ram_rd_addr = {rd_bank_q, rd_word_q};
    assign tile_err    = tile_err_q;

    always_comb begin
        wr_st_d    = wr_st_q;
        wr_bank_d  = wr_bank_q;
        pix_cnt_d  = pix_cnt_q;
        bank_d     = bank_q;
        tile_err_d = tile_err_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_st_d    = rd_st_q;
        rd_bank_d  = rd_bank_q;
        rd_word_d  = rd_word_q;
        rd_all_d   = rd_all_q;
        issue      = 1'b0;
        issue_last = 1'b0;

        hs      = s_valid && s_ready;
        // s_first forces this pixel to (0,0); the aborted partial tile is simply overwritten.
        pos     = s_first ? '0 : pix_cnt_q;
        r       = pos[CNT_W-1 -: RW];
        c       = pos[CW-1:0];
        wr_en_d = hs;
        if (hs) begin
`ifdef ROTATE_BUF_CTRL_CCW_EN
            wr_addr_d = {wr_bank_q, ~c, r};
`else
            wr_addr_d = {wr_bank_q, c, ~r};
`endif
            wr_data_d = s_data;
            if (s_first && (pix_cnt_q != '0)) begin
                tile_err_d = 1'b1;
            end
        end

        case (wr_st_q)
            W_WAIT: begin
                if (bank_q[wr_bank_q] == FREE) begin
                    bank_d[wr_bank_q] = FILLING;
                    pix_cnt_d         = '0;
                    wr_st_d           = W_FILL;
                end
            end
            default: begin
                if (hs) begin
                    pix_cnt_d = pos + CNT_W'(1);
                    if (pos == CNT_W'(PIX_PER_TILE - 1)) begin
                        bank_d[wr_bank_q] = FULL;
                        wr_bank_d         = ~wr_bank_q;
                        if (bank_q[~wr_bank_q] == FREE) begin
                            bank_d[~wr_bank_q] = FILLING;
                        end else begin
                            wr_st_d = W_WAIT;
                        end
                    end
                end
            end
        endcase

        // Read side only touches FULL/DRAINING banks, never the bank the writer is moving.
        case (rd_st_q)
            R_IDLE: begin
                if (bank_q[rd_bank_q] == FULL) begin
                    bank_d[rd_bank_q] = DRAINING;
                    rd_word_d         = '0;
                    rd_all_d          = 1'b0;
                    rd_st_d           = R_RUN;
                end
            end
            default: begin
                if (!rd_all_q && can_issue) begin
                    issue      = 1'b1;
                    issue_last = (rd_word_q == WD'(WORDS_PER_BANK - 1));
                    rd_word_d  = rd_word_q + WD'(1);
                    rd_all_d   = issue_last;
                end
                if (m_valid && m_ready && m_last) begin
                    bank_d[rd_bank_q] = FREE;
                    rd_bank_d         = ~rd_bank_q;
                    rd_st_d           = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st_q    <= W_WAIT;
            wr_bank_q  <= 1'b0;
            pix_cnt_q  <= '0;
            bank_q[0]  <= FREE;
            bank_q[1]  <= FREE;
            tile_err_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_st_q    <= R_IDLE;
            rd_bank_q  <= 1'b0;
            rd_word_q  <= '0;
            rd_all_q   <= 1'b0;
        end else begin
            wr_st_q    <= wr_st_d;
            wr_bank_q  <= wr_bank_d;
            pix_cnt_q  <= pix_cnt_d;
            bank_q     <= bank_d;
            tile_err_q <= tile_err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_st_q    <= rd_st_d;
            rd_bank_q  <= rd_bank_d;
            rd_word_q  <= rd_word_d;
            rd_all_q   <= rd_all_d;
        end
    end

    rotate_buf_ofifo #(
        .DW (RD_DW)
    ) u_ofifo (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .issue_last (issue_last),
        .can_issue  (can_issue),
        .rd_data    (ram_rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

endmodule
